// File: rtl/codec_init_sequencer_if.sv
// Command handshake between the codec init sequencer (master) and the
// I2C register programmer (slave): CMD/GO out, READY/ACK back.
interface codec_init_sequencer_if;
  logic [3:0] CMD;
  logic       GO;
  logic       READY;
  logic       ACK;

  modport master (output CMD, output GO, input READY, input ACK);
  modport slave  (input CMD, input GO, output READY, output ACK);
endinterface

// File: rtl/codec_init_sequencer.sv
// Codec init sequencer: settle, then write commands 1..NUM_CMDS through the programmer with retries.
// Optional CODEC_INIT_AUTOSTART_EN: run the sequence once automatically after reset release.
module codec_init_sequencer #(
  parameter int NUM_CMDS       = 10,
  parameter int SETTLE_CYCLES  = 1000,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          CLK,
  input  logic                          RST_L,
  input  logic                          START,
  codec_init_sequencer_if.master        prog,
  output logic                          BUSY,
  output logic                          DONE,
  output logic                          ERROR,
  output logic [3:0]                    ERR_CMD
);

  localparam int              AW          = $clog2(MAX_RETRY + 1);
  localparam logic [15:0]     SETTLE_LAST = 16'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [15:0]     TMO_LIMIT   = 16'(TIMEOUT_CYCLES);
  localparam logic [3:0]      LAST_CMD    = 4'(NUM_CMDS);
  localparam logic [AW-1:0]   RETRY_LIMIT = AW'(MAX_RETRY);

  typedef enum logic [3:0] {
    IDLE, SETTLE, ISSUE, WAIT_BUSY, WAIT_DONE, CHECK, NEXT, DONE_ST, FAIL_ST
  } state_t;

  state_t          state_reg, state_next;
  logic [3:0]      cmd_reg, cmd_next;
  logic [AW-1:0]   attempt_reg, attempt_next;
  logic            ack_reg, ack_next;
  logic            done_reg, done_next;
  logic            error_reg, error_next;
  logic [3:0]      err_cmd_reg, err_cmd_next;
  logic [15:0]     settle_cnt_reg;
  logic [15:0]     tmo_cnt_reg;
  logic            idle_start;
  logic            launch;
  logic            timeout;

`ifdef CODEC_INIT_AUTOSTART_EN
  logic auto_fired_reg;
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) auto_fired_reg <= 1'b0;
    else        auto_fired_reg <= 1'b1;
  end
  assign idle_start = START | ~auto_fired_reg;
`else
  assign idle_start = START;
`endif

  assign timeout = (tmo_cnt_reg >= TMO_LIMIT);

  always_comb begin
    state_next   = state_reg;
    cmd_next     = cmd_reg;
    attempt_next = attempt_reg;
    ack_next     = ack_reg;
    done_next    = done_reg;
    error_next   = error_reg;
    err_cmd_next = err_cmd_reg;
    launch       = 1'b0;
    case (state_reg)
      IDLE:    launch = idle_start;
      SETTLE:  if (settle_cnt_reg >= SETTLE_LAST) state_next = ISSUE;
      ISSUE: begin
        if (timeout) begin
          state_next = CHECK;
          ack_next   = 1'b0;
        end else if (prog.READY) begin
          state_next = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (timeout) begin
          state_next = CHECK;
          ack_next   = 1'b0;
        end else if (!prog.READY) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // ACK is only meaningful on the cycle READY comes back high
        if (timeout) begin
          state_next = CHECK;
          ack_next   = 1'b0;
        end else if (prog.READY) begin
          state_next = CHECK;
          ack_next   = prog.ACK;
        end
      end
      CHECK: begin
        if (ack_reg) begin
          state_next = NEXT;
        end else if (attempt_reg < RETRY_LIMIT) begin
          attempt_next = attempt_reg + AW'(1);
          state_next   = ISSUE;
        end else begin
          state_next   = FAIL_ST;
          error_next   = 1'b1;
          err_cmd_next = cmd_reg;
        end
      end
      NEXT: begin
        if (cmd_reg == LAST_CMD) begin
          state_next = DONE_ST;
          done_next  = 1'b1;
        end else begin
          cmd_next     = cmd_reg + 4'd1;
          attempt_next = AW'(1);
          state_next   = ISSUE;
        end
      end
      DONE_ST: launch = START;
      FAIL_ST: launch = START;
      default: state_next = IDLE;
    endcase
    if (launch) begin
      state_next   = SETTLE;
      cmd_next     = 4'd1;
      attempt_next = AW'(1);
      done_next    = 1'b0;
      error_next   = 1'b0;
      err_cmd_next = 4'd0;
    end
  end

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      state_reg      <= IDLE;
      cmd_reg        <= 4'd0;
      attempt_reg    <= '0;
      ack_reg        <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
      err_cmd_reg    <= 4'd0;
      settle_cnt_reg <= 16'd0;
      tmo_cnt_reg    <= 16'd0;
    end else begin
      state_reg   <= state_next;
      cmd_reg     <= cmd_next;
      attempt_reg <= attempt_next;
      ack_reg     <= ack_next;
      done_reg    <= done_next;
      error_reg   <= error_next;
      err_cmd_reg <= err_cmd_next;
      // both counters restart on every state entry and saturate
      if (state_next != state_reg)       tmo_cnt_reg <= 16'd0;
      else if (tmo_cnt_reg != 16'hFFFF)  tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
      if (state_reg != SETTLE || state_next != SETTLE) settle_cnt_reg <= 16'd0;
      else if (settle_cnt_reg != 16'hFFFF)             settle_cnt_reg <= settle_cnt_reg + 16'd1;
    end
  end

  assign BUSY     = !(state_reg inside {IDLE, DONE_ST, FAIL_ST});
  assign DONE     = done_reg;
  assign ERROR    = error_reg;
  assign ERR_CMD  = err_cmd_reg;
  assign prog.GO  = (state_reg == WAIT_BUSY);
  assign prog.CMD = (state_reg inside {ISSUE, WAIT_BUSY, WAIT_DONE, CHECK, NEXT}) ? cmd_reg : 4'd0;

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Directed bench for codec_init_sequencer with a behavioural I2C programmer model.
module tb_codec_init_sequencer;

  logic       clk;
  logic       rst_l;
  logic       start;
  logic       busy, done, error;
  logic [3:0] err_cmd;

  codec_init_sequencer_if bus ();

  codec_init_sequencer dut (
    .CLK     (clk),
    .RST_L   (rst_l),
    .START   (start),
    .prog    (bus.master),
    .BUSY    (busy),
    .DONE    (done),
    .ERROR   (error),
    .ERR_CMD (err_cmd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // programmer model controls and observations
  int nack_cmd    = 0;
  int nack_times  = 0;
  int stuck_cmd   = 0;
  int go_cnt [16];
  int go_q [$];
  int cmd_bad     = 0;
  int last_go_run = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("ok   %s = %0d", tag, got);
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    int  m_cnt;
    bit  m_busy;
    bit  prev_go;
    int  prev_cmd;
    int  cur_cmd;
    int  go_run;
    m_cnt = 0; m_busy = 0; prev_go = 0; prev_cmd = 0; cur_cmd = 0; go_run = 0;
    bus.READY = 1'b1;
    bus.ACK   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_l) begin
        bus.READY = 1'b1;
        bus.ACK   = 1'b0;
        m_busy    = 0;
        prev_go   = 0;
        go_run    = 0;
      end else begin
        if (bus.GO && !prev_go) begin
          cur_cmd = int'(bus.CMD);
          go_cnt[bus.CMD]++;
          go_q.push_back(cur_cmd);
          $display("xfer cmd=%0d attempt=%0d", cur_cmd, go_cnt[bus.CMD]);
          if (cur_cmd != stuck_cmd) begin
            m_busy = 1;
            m_cnt  = 0;
          end
        end
        if (m_busy) begin
          m_cnt++;
          if (m_cnt == 2) bus.READY = 1'b0;
          if (m_cnt == 40) begin
            bus.ACK   = !(cur_cmd == nack_cmd && go_cnt[cur_cmd] <= nack_times);
            bus.READY = 1'b1;
            m_busy    = 0;
          end
        end
        if (bus.GO) go_run++;
        else if (prev_go) begin
          last_go_run = go_run;
          go_run      = 0;
        end
        if (prev_go && bus.GO && int'(bus.CMD) != prev_cmd) cmd_bad++;
        prev_go  = bus.GO;
        prev_cmd = int'(bus.CMD);
      end
    end
  end

  task automatic clear_log();
    go_q.delete();
    for (int i = 0; i < 16; i++) go_cnt[i] = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (!(done || error) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(done || error)) check("end_reached", 0, 1);
    @(negedge clk);
  endtask

  task automatic check_seq(input string tag, input int exp [$]);
    check({tag, "_len"}, go_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < go_q.size()) check(tag, go_q[i], exp[i]);
  endtask

  initial begin
    int exp [$];
    int n;
    start = 1'b0;
    rst_l = 1'b0;
    clear_log();
    repeat (3) @(negedge clk);
    check("rst_cmd", bus.CMD, 0);
    check("rst_go", bus.GO, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_err_cmd", err_cmd, 0);
    rst_l = 1'b1;

`ifdef CODEC_INIT_AUTOSTART_EN
    wait_end(5000);
    check("auto_done", done, 1);
    check("auto_error", error, 0);
    exp = {};
    for (int c = 1; c <= 10; c++) exp.push_back(c);
    check_seq("auto_seq", exp);
`else
    repeat (20) @(negedge clk);
    check("no_autostart_busy", busy, 0);
    check("no_autostart_go_cnt", go_q.size(), 0);
`endif

    // nominal run, with settle latency from START to first GO
    clear_log();
    @(negedge clk);
    start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (n == 1) begin
        check("start_busy", busy, 1);
        check("settle_cmd", bus.CMD, 0);
      end
    end while (!bus.GO && n < 3000);
    check("settle_latency", n, 1002);
    wait_end(5000);
    check("nom_done", done, 1);
    check("nom_error", error, 0);
    check("nom_busy", busy, 0);
    check("nom_cmd", bus.CMD, 0);
    check("nom_go", bus.GO, 0);
    exp = {};
    for (int c = 1; c <= 10; c++) exp.push_back(c);
    check_seq("nom_seq", exp);

    // single NACK on CMD 5, with a START ignored while busy
    clear_log();
    nack_cmd = 5; nack_times = 1;
    pulse_start();
    check("restart_done_clr", done, 0);
    repeat (1100) @(negedge clk);
    pulse_start();
    wait_end(5000);
    check("nack1_done", done, 1);
    check("nack1_error", error, 0);
    check("nack1_cmd5_gos", go_cnt[5], 2);
    exp = {1, 2, 3, 4, 5, 5, 6, 7, 8, 9, 10};
    check_seq("nack1_seq", exp);

    // persistent NACK on CMD 7
    clear_log();
    nack_cmd = 7; nack_times = 99;
    pulse_start();
    wait_end(5000);
    check("nack7_error", error, 1);
    check("nack7_err_cmd", err_cmd, 7);
    check("nack7_done", done, 0);
    check("nack7_busy", busy, 0);
    check("nack7_cmd7_gos", go_cnt[7], 3);
    check("nack7_cmd8_gos", go_cnt[8], 0);
    exp = {1, 2, 3, 4, 5, 6, 7, 7, 7};
    check_seq("nack7_seq", exp);

    // programmer never goes busy on CMD 3
    clear_log();
    nack_cmd = 0; nack_times = 0; stuck_cmd = 3;
    pulse_start();
    check("restart_err_clr", error, 0);
    check("restart_err_cmd_clr", err_cmd, 0);
    wait_end(20000);
    check("tmo_error", error, 1);
    check("tmo_err_cmd", err_cmd, 3);
    check("tmo_done", done, 0);
    check("tmo_cmd3_gos", go_cnt[3], 3);
    check("tmo_go_len", last_go_run, 4097);
    check("tmo_go", bus.GO, 0);

    // reset in the middle of CMD 4 while the programmer is busy
    clear_log();
    stuck_cmd = 0;
    pulse_start();
    n = 0;
    while (!(bus.CMD == 4'd4 && !bus.GO && !bus.READY) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("cmd4_wait_done_seen", (n < 3000), 1);
    #2 rst_l = 1'b0;
    #1;
    check("mid_rst_cmd", bus.CMD, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_go", bus.GO, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_error", error, 0);
    repeat (3) @(negedge clk);
    clear_log();
    rst_l = 1'b1;
    pulse_start();
    wait_end(5000);
    check("post_rst_done", done, 1);
    check("post_rst_error", error, 0);
    exp = {};
    for (int c = 1; c <= 10; c++) exp.push_back(c);
    check_seq("post_rst_seq", exp);

    check("cmd_stable_during_go", cmd_bad, 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
